aes_round_sequencer: RTL and testbench

//  Control and state-holding block around the combinational AES round datapath
//  (SubBytes/ShiftRows/MixColumns/AddRoundKey). Accepts one block plus cipher key
//  via valid/ready, fetches round keys from the key-schedule unit over a
//  req/ack handshake, and iterates rounds 0..NR. Presents the ciphertext on a

---
 rtl/aes_pkg.sv | 30 +++
 rtl/aes_round_sequencer.sv | 103 ++++++++++
 tb/tb_aes_round_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared constants for the AES round sequencer: round count, datapath round
// selector encodings and sequencer FSM state encodings.
package aes_pkg;

    localparam int AES128_NR = 10;
    localparam int ROUND_W   = 4;

    localparam logic [1:0] SEL_INIT  = 2'd0;
    localparam logic [1:0] SEL_MID   = 2'd1;
    localparam logic [1:0] SEL_FINAL = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_APPLY = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // Round 0 is the bare AddRoundKey; the last round skips MixColumns.
    function automatic logic [1:0] round_sel(input logic [ROUND_W-1:0] round,
                                             input logic [ROUND_W-1:0] last);
        if (round == '0)
            return SEL_INIT;
        else if (round == last)
            return SEL_FINAL;
        else
            return SEL_MID;
    endfunction

endpackage

// File: rtl/aes_round_sequencer.sv
// Sequencer around an external combinational AES round datapath: accepts a block,
// fetches round keys 0..NR over req/ack, iterates rounds, presents ciphertext.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR     = AES128_NR,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] plain_text,
    input  logic [DATA_W-1:0] key,
    output logic [DATA_W-1:0] ks_key,
    output logic              rk_req,
    output logic [3:0]        rk_idx,
    input  logic              rk_ack,
    input  logic [DATA_W-1:0] rk_data,
    output logic [DATA_W-1:0] rnd_state,
    output logic [1:0]        rnd_sel,
    output logic [DATA_W-1:0] rnd_key,
    input  logic [DATA_W-1:0] rnd_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] cipher_text,
    output logic              busy
);

    if (NR < 1 || NR > 14) begin : g_bad_nr
        $error("aes_round_sequencer: NR must be in 1..14 for a 4-bit round counter");
    end

    localparam logic [ROUND_W-1:0] LAST = ROUND_W'(NR);

    seq_state_e         state;
    seq_state_e         state_next;
    logic [ROUND_W-1:0] round;
    logic               accept;
    logic               last_round;

    assign accept     = in_valid && in_ready;
    assign last_round = (round == LAST);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept)    state_next = ST_FETCH;
            ST_FETCH: if (rk_ack)    state_next = ST_APPLY;
            ST_APPLY: state_next = last_round ? ST_DONE : ST_FETCH;
            ST_DONE:  if (out_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // in_ready is registered so it stays low until the first edge after reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            round       <= '0;
            rk_idx      <= '0;
            in_ready    <= 1'b0;
            rnd_state   <= '0;
            rnd_key     <= '0;
            ks_key      <= '0;
            cipher_text <= '0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next == ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        rnd_state <= plain_text;
                        ks_key    <= key;
                        round     <= '0;
                        rk_idx    <= '0;
                    end
                end
                ST_FETCH: begin
                    if (rk_ack)
                        rnd_key <= rk_data;
                end
                ST_APPLY: begin
                    rnd_state <= rnd_result;
                    if (last_round) begin
                        cipher_text <= rnd_result;
                    end else begin
                        round  <= round + 1'b1;
                        rk_idx <= round + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs decode from state so an async reset drops them at once.
    assign rk_req    = (state == ST_FETCH);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign rnd_sel   = (state == ST_APPLY) ? round_sel(round, LAST) : SEL_INIT;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench: an AES-128 round/key-schedule model serves the sequencer, a
// queue of expected ciphertexts is checked as blocks complete.
module tb_aes_round_sequencer;

    logic         clk;
    logic         rstn;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plain_text;
    logic [127:0] key;
    logic [127:0] ks_key;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic         rk_ack = 1'b0;
    logic [127:0] rk_data = '0;
    logic [127:0] rnd_state;
    logic [1:0]   rnd_sel;
    logic [127:0] rnd_key;
    logic [127:0] rnd_result;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] cipher_text;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    logic [127:0] exp_q[$];
    int           idx_q[$];
    int           max_delay = 0;
    logic         spur_en   = 1'b0;
    longint       acc_t     = 0;

    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes_round_sequencer #(.NR(10), .DATA_W(128)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .plain_text(plain_text), .key(key), .ks_key(ks_key),
        .rk_req(rk_req), .rk_idx(rk_idx), .rk_ack(rk_ack), .rk_data(rk_data),
        .rnd_state(rnd_state), .rnd_sel(rnd_sel), .rnd_key(rnd_key),
        .rnd_result(rnd_result),
        .out_valid(out_valid), .out_ready(out_ready), .cipher_text(cipher_text),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- AES-128 reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254, followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            v = gm(v, v);
            if (i >= 1) v = gm(v, a);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s,
                                               input logic [127:0] k,
                                               input logic [1:0]   sel);
        logic [7:0]   b[16];
        logic [7:0]   t[16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        if (sel == 2'd0) return s ^ k;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r+4*c] = b[r+4*((c+r)%4)];
        if (sel == 2'd1) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gm(a0, 8'd2) ^ gm(a1, 8'd3) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gm(a1, 8'd2) ^ gm(a2, 8'd3) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'd2) ^ gm(a3, 8'd3);
                t[4*c+3] = gm(a0, 8'd3) ^ a1 ^ a2 ^ gm(a3, 8'd2);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] k, input int idx);
        logic [31:0] w[44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])};
                tmp = tmp ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        if (idx < 0 || idx > 10) return '0;
        return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
    endfunction

    assign rnd_result = aes_round(rnd_state, rnd_key, rnd_sel);

    // ---------------- key-schedule responder ----------------
    logic req_seen  = 1'b0;
    int   wait_left = 0;

    always @(negedge clk) begin
        if (rk_req === 1'b1) begin
            if (!req_seen) begin
                req_seen  = 1'b1;
                wait_left = (max_delay > 0) ? int'($urandom_range(max_delay, 0)) : 0;
                idx_q.push_back(int'(rk_idx));
            end
            if (wait_left == 0) begin
                rk_ack  = 1'b1;
                rk_data = round_key(ks_key, int'(rk_idx));
            end else begin
                rk_ack    = 1'b0;
                rk_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
                wait_left = wait_left - 1;
            end
        end else begin
            req_seen = 1'b0;
            rk_ack   = spur_en;
            rk_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_seq();
        logic ok;
        ok = (idx_q.size() == 11);
        for (int i = 0; i < idx_q.size() && ok; i++)
            if (idx_q[i] != i) ok = 1'b0;
        chki("rk_idx_seq_len", idx_q.size(), 11);
        chk1("rk_idx_seq_order", ok, 1'b1);
    endtask

    task automatic send(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] exp);
        int n;
        n = 0;
        plain_text = pt;
        key        = k;
        in_valid   = 1'b1;
        exp_q.push_back(exp);
        while (in_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk1("accept_in_time", n < 400, 1'b1);
        @(posedge clk);
        acc_t = longint'($time);
        @(negedge clk);
        in_valid   = 1'b0;
        plain_text = {$urandom(), $urandom(), $urandom(), $urandom()};
        key        = {$urandom(), $urandom(), $urandom(), $urandom()};
        chk("state_loaded", rnd_state, pt);
        chk("ks_key_loaded", ks_key, k);
        chk1("busy_after_accept", busy, 1'b1);
    endtask

    task automatic recv(input int bp, output int lat);
        int           n;
        logic [127:0] got;
        logic [127:0] exp;
        logic [127:0] key_snap;
        n = 0;
        while (out_valid !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk1("out_valid_in_time", n < 400, 1'b1);
        lat = int'((longint'($time) - 5 - acc_t) / 10);
        got = cipher_text;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk("cipher_text", got, exp);
        if (bp > 0) begin
            key_snap   = rnd_key;
            in_valid   = 1'b1;
            plain_text = {$urandom(), $urandom(), $urandom(), $urandom()};
            out_ready  = 1'b0;
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                chk1("bp_out_valid_held", out_valid, 1'b1);
                chk("bp_cipher_stable", cipher_text, got);
                chk1("bp_in_ready_low", in_ready, 1'b0);
                chk("bp_rnd_key_stable", rnd_key, key_snap);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk1("out_valid_dropped", out_valid, 1'b0);
        chk1("ready_after_handshake", in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        int lat2;
        int n;
        rstn       = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        plain_text = '0;
        key        = '0;

        #1;
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_rk_req", rk_req, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk("rst_cipher_text", cipher_text, '0);
        chk("rst_rnd_key", rnd_key, '0);
        chk("rst_ks_key", ks_key, '0);
        chk("rst_rnd_state", rnd_state, '0);

        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk1("ready_after_reset", in_ready, 1'b1);

        // C.1 vector with zero-wait acknowledge
        idx_q.delete();
        send(C1_PT, C1_KEY, C1_CT);
        recv(0, lat);
        chki("latency_zero_wait", lat, 22);
        chk_seq();

        // random ack delays plus spurious acks outside FETCH
        max_delay = 5;
        spur_en   = 1'b1;
        idx_q.delete();
        send(C1_PT, C1_KEY, C1_CT);
        recv(0, lat);
        chk_seq();

        // output backpressure with spurious acks in DONE
        max_delay = 0;
        send(C1_PT, C1_KEY, C1_CT);
        recv(7, lat);
        spur_en = 1'b0;

        // back-to-back blocks, second offered while the first is in flight
        send(C1_PT, C1_KEY, C1_CT);
        fork
            send('0, '0, Z_CT);
            recv(0, lat);
        join
        recv(0, lat2);
        chki("scoreboard_drained", exp_q.size(), 0);

        // reset while fetching round 5
        max_delay = 2;
        send(C1_PT, C1_KEY, C1_CT);
        n = 0;
        while (!(rk_req === 1'b1 && rk_idx === 4'd5) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk1("reached_round5", n < 400, 1'b1);
        #2 rstn = 1'b0;
        #1;
        chk1("abort_rk_req", rk_req, 1'b0);
        chk1("abort_out_valid", out_valid, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk("abort_cipher_cleared", cipher_text, '0);
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk1("ready_after_abort", in_ready, 1'b1);
        chk1("no_partial_output", out_valid, 1'b0);

        max_delay = 0;
        idx_q.delete();
        send(C1_PT, C1_KEY, C1_CT);
        recv(0, lat);
        chki("latency_after_abort", lat, 22);
        chk_seq();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
